// File: rtl/pll_pkg.sv
// pll_pkg: shared state encoding and parameter range check for pll_supervisor
package pll_pkg;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;
  function automatic bit params_ok(int num_clks, int rst_hold, int lock_filter,
                                   int stagger, int timeout, int max_retry);
    return num_clks >= 1 && num_clks <= 8 && rst_hold >= 1 && lock_filter >= 1 &&
           stagger >= 1 && timeout > lock_filter && max_retry >= 1;
  endfunction
endpackage

// File: rtl/pll_supervisor_lock_sync.sv
// lock_sync: 2-FF synchroniser for an asynchronous level, async active-low reset to 0
//   clk, rst_n : destination clock and reset
//   d          : asynchronous input level
//   q          : level synchronised to clk
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: EHXPLLL lock supervisor, retry/fault handling and staggered domain reset release
//   clki         : PLL reference clock
//   rst_n        : asynchronous active-low reset
//   lock         : raw PLL LOCK (asynchronous)
//   restart      : one-cycle pulse, full re-sequence and fault clear
//   pll_rst      : drives EHXPLLL RST (PLLRST_ENA="ENABLED")
//   domain_rst_n : per-domain active-low reset requests, bit 0 released first
//   ready        : all domains released with stable lock
//   fault        : retry budget exhausted
//   retry_cnt    : failed attempts since last restart/reset
module pll_supervisor
  import pll_pkg::*;
#(
  parameter int NUM_CLKS    = 4,
  parameter int RST_HOLD    = 8,
  parameter int LOCK_FILTER = 16,
  parameter int STAGGER     = 4,
  parameter int TIMEOUT     = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                           clki,
  input  logic                           rst_n,
  input  logic                           lock,
  input  logic                           restart,
  output logic                           pll_rst,
  output logic [NUM_CLKS-1:0]            domain_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [FW-1:0] FILT_DONE = FW'(LOCK_FILTER);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  if (!params_ok(NUM_CLKS, RST_HOLD, LOCK_FILTER, STAGGER, TIMEOUT, MAX_RETRY)) begin : g_param_check
    $error("pll_supervisor: parameter out of range");
  end

  logic                lock_s;
  state_e              state_q, state_d, fail_st;
  logic [HW-1:0]       hold_q, hold_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [TW-1:0]       to_q, to_d;
  logic [SW-1:0]       stag_q, stag_d;
  logic [NUM_CLKS-1:0] dom_q, dom_d;
  logic [RW-1:0]       retry_q, retry_d, retry_inc;
  logic                pll_rst_q, pll_rst_d, ready_q, ready_d, fault_q, fault_d;

  lock_sync u_lock_sync (
    .clk   (clki),
    .rst_n (rst_n),
    .d     (lock),
    .q     (lock_s)
  );

  // Counters default to 0 so every state is entered with fresh counts.
  // The release stagger shifts a 1 into the domain mask whenever stag_q hits 0.
  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    filt_d    = '0;
    to_d      = '0;
    stag_d    = '0;
    dom_d     = '0;
    retry_d   = retry_q;
    retry_inc = retry_q + 1'b1;
    fail_st   = retry_inc == RETRY_MAX ? FAULT : RESET_PLL;
    if (restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          hold_d  = hold_q == HOLD_LAST ? '0 : hold_q + 1'b1;
          state_d = hold_q == HOLD_LAST ? WAIT_LOCK : RESET_PLL;
        end
        WAIT_LOCK: begin
          filt_d = lock_s ? filt_q + 1'b1 : '0;
          to_d   = to_q + 1'b1;
          if (filt_d == FILT_DONE) state_d = RELEASE;
          else if (to_q == TO_LAST) begin
            state_d = fail_st;
            retry_d = retry_inc;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = fail_st;
            retry_d = retry_inc;
          end else begin
            dom_d  = stag_q == '0 ? (dom_q << 1) | NUM_CLKS'(1) : dom_q;
            stag_d = stag_q == '0 ? STAG_LAST : stag_q - 1'b1;
            if (&dom_d) begin
              state_d = RUN;
              retry_d = '0;
            end
          end
        end
        RUN: begin
          dom_d   = lock_s ? dom_q : '0;
          state_d = lock_s ? RUN : fail_st;
          retry_d = lock_s ? retry_q : retry_inc;
        end
        default: ;
      endcase
    end
    pll_rst_d = state_d == RESET_PLL || state_d == FAULT;
    ready_d   = state_d == RUN;
    fault_d   = state_d == FAULT;
  end

  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      hold_q    <= '0;
      filt_q    <= '0;
      to_q      <= '0;
      stag_q    <= '0;
      dom_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      filt_q    <= filt_d;
      to_q      <= to_d;
      stag_q    <= stag_d;
      dom_q     <= dom_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = dom_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign retry_cnt    = retry_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: vector table, directed corner sequences and random lock traffic against a timeline model
module tb_pll_supervisor;
  localparam int NUM = 4, RST_HOLD = 8, LOCK_FILTER = 16, STAGGER = 4, TIMEOUT = 1000, MAX_RETRY = 3;
  localparam int P_HOLD = 0, P_WAIT = 1, P_REL = 2, P_FAULT = 3;

  logic       clki = 1'b0;
  logic       rst_n, lock, restart;
  logic       pll_rst, ready, fault;
  logic [3:0] domain_rst_n;
  logic [1:0] retry_cnt;

  pll_supervisor dut (
    .clki         (clki),
    .rst_n        (rst_n),
    .lock         (lock),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
  );

  always #5 clki = ~clki;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase + time-in-phase; released domains derived arithmetically from time in release.
  int ph, t, run, retries;
  bit h0, h1;

  task automatic m_reset();
    ph = P_HOLD; t = 0; run = 0; retries = 0; h0 = 0; h1 = 0;
  endtask

  function automatic int m_rel();
    int r;
    r = (t - 1) / STAGGER + 1;
    return (ph == P_REL && t > 0) ? (r > NUM ? NUM : r) : 0;
  endfunction

  task automatic m_fail();
    retries++;
    ph = retries == MAX_RETRY ? P_FAULT : P_HOLD;
    t = 0;
  endtask

  task automatic m_step();
    bit ls;
    ls = h1; h1 = h0; h0 = lock;
    if (restart) begin
      ph = P_HOLD; t = 0; retries = 0;
    end else if (ph == P_HOLD) begin
      t++;
      if (t == RST_HOLD) begin ph = P_WAIT; t = 0; run = 0; end
    end else if (ph == P_WAIT) begin
      t++;
      run = ls ? run + 1 : 0;
      if (run == LOCK_FILTER) begin ph = P_REL; t = 0; end
      else if (t == TIMEOUT) m_fail();
    end else if (ph == P_REL) begin
      if (!ls) m_fail();
      else begin
        t++;
        if (m_rel() == NUM) retries = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_out();
    int r;
    r = m_rel();
    return 32'({ph == P_HOLD || ph == P_FAULT, 4'((1 << r) - 1), r == NUM, ph == P_FAULT, 2'(retries)});
  endfunction

  task automatic tick();
    @(posedge clki);
    if (!rst_n) m_reset(); else m_step();
    #1;
    chk("model", 32'({pll_rst, domain_rst_n, ready, fault, retry_cnt}), m_out());
  endtask

  typedef struct {
    int         cyc;
    logic       lk;
    logic       pr;
    logic [3:0] dm;
    logic       rd;
    logic       ft;
    logic [1:0] rc;
  } vec_t;
  vec_t vecs [19];

  task automatic chk_all(input string nm, input logic pr, input logic [3:0] dm, input logic rd,
                         input logic ft, input logic [1:0] rc);
    chk({nm, ".pll_rst"}, 32'(pll_rst), 32'(pr));
    chk({nm, ".domain_rst_n"}, 32'(domain_rst_n), 32'(dm));
    chk({nm, ".ready"}, 32'(ready), 32'(rd));
    chk({nm, ".fault"}, 32'(fault), 32'(ft));
    chk({nm, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // clean start, then lock loss in RUN and re-sequence; edge numbers counted from reset release
    vecs = '{
      '{0,  1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0},
      '{7,  1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0},
      '{1,  1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0},
      '{42, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0},
      '{18, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0},
      '{1,  1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 2'd0},
      '{3,  1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 2'd0},
      '{1,  1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 2'd0},
      '{4,  1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 2'd0},
      '{3,  1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 2'd0},
      '{1,  1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0},
      '{20, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0},
      '{2,  1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0},
      '{1,  1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd1},
      '{7,  1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 2'd1},
      '{1,  1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd1},
      '{16, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd1},
      '{1,  1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 2'd1},
      '{12, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0}
    };
    m_reset();
    rst_n = 1'b0; lock = 1'b0; restart = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      lock = vecs[i].lk;
      repeat (vecs[i].cyc) tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pr, vecs[i].dm, vecs[i].rd, vecs[i].ft, vecs[i].rc);
    end

    // glitch filter: 10 high, 5 low, then steady high
    restart = 1'b1; tick(); restart = 1'b0;
    lock = 1'b0;
    repeat (10) tick();
    lock = 1'b1; repeat (10) tick();
    lock = 1'b0; repeat (5) tick();
    lock = 1'b1; repeat (18) tick();
    chk_all("glitch_hold", 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_all("glitch_rel", 1'b0, 4'h1, 1'b0, 1'b0, 2'd0);

    // timeout to fault
    lock = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
    repeat (1008) tick();
    chk_all("timeout1", 1'b1, 4'h0, 1'b0, 1'b0, 2'd1);
    repeat (2015) tick();
    chk_all("timeout3_pre", 1'b0, 4'h0, 1'b0, 1'b0, 2'd2);
    tick();
    chk_all("fault", 1'b1, 4'h0, 1'b0, 1'b1, 2'd3);
    repeat (20) tick();
    chk_all("fault_held", 1'b1, 4'h0, 1'b0, 1'b1, 2'd3);

    // restart in FAULT
    lock = 1'b1; restart = 1'b1; tick(); restart = 1'b0;
    chk_all("restart_fault", 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);

    // restart coinciding with lock loss while 0011 is released
    repeat (28) tick();
    lock = 1'b0;
    repeat (2) tick();
    chk_all("rel_0011", 1'b0, 4'h3, 1'b0, 1'b0, 2'd0);
    restart = 1'b1; tick(); restart = 1'b0;
    chk_all("restart_rel", 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);

    // async reset between stagger steps
    lock = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = domain_rst_n == 4'b0011;
    end
    chk("wait_0011", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_all("async_rst", 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // random lock traffic with occasional restart
    for (int c = 0; c < 6000;) begin
      int len;
      lock = ~lock;
      len = lock ? int'($urandom_range(1, 60))
                 : ($urandom_range(0, 7) == 0 ? int'($urandom_range(900, 1300)) : int'($urandom_range(1, 8)));
      for (int k = 0; k < len; k++) begin
        restart = $urandom_range(0, 399) == 0;
        tick();
      end
      c += len;
    end
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised lock supervisor and reset sequencer for the ECP5 EHXPLLL clock generator. It runs on the PLL reference clock and drives the PLL `RST` pin. It watches the asynchronous `LOCK` output, filters it and releases up to eight per-domain reset requests in a fixed staggered order. On lock loss or lock timeout it re-arms the PLL automatically, and it latches a fault after a configurable number of failed attempts. It sits between the PLL wrapper and every clocked subsystem that uses a PLL output.

## Interface
Parameters:
- `NUM_CLKS`, 4: number of downstream clock domains; range 1..8.
- `RST_HOLD`, 8: cycles `pll_rst` is held high per attempt; at least 1.
- `LOCK_FILTER`, 16: consecutive synchronised-high lock samples that count as a stable lock; at least 1.
- `STAGGER`, 4: cycles between successive domain reset releases; at least 1.
- `TIMEOUT`, 1000: cycles allowed in WAIT_LOCK before retrying; must be greater than `LOCK_FILTER`.
- `MAX_RETRY`, 3: failed attempts before FAULT; at least 1.

Ports:
- `clki`, in, 1: reference clock (PLL input clock).
- `rst_n`, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `lock`, in, 1: raw PLL LOCK, asynchronous to `clki`.
- `restart`, in, 1: single-cycle pulse that forces a full re-sequence and clears the fault.
- `pll_rst`, out, 1: PLL reset, active-high.
- `domain_rst_n`, out, NUM_CLKS: per-domain reset request, active-low. Each consumer synchronises its bit into its own domain.
- `ready`, out, 1: all domains released and lock stable.
- `fault`, out, 1: retry budget exhausted.
- `retry_cnt`, out, $clog2(MAX_RETRY+1): failed attempts since the last restart or reset.

## Operation
- `lock` passes through a 2-FF synchroniser to give `lock_s`; all decisions use `lock_s` only.
- States are RESET_PLL, WAIT_LOCK, RELEASE, RUN and FAULT. Reset state is RESET_PLL.
- RESET_PLL:
  - `pll_rst`=1 and all `domain_rst_n`=0.
  - Counts `RST_HOLD` cycles, then moves to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0. The filter counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - When the filter count reaches `LOCK_FILTER`, move to RELEASE.
  - When the timeout counter reaches `TIMEOUT`, `retry_cnt`+1. If the new value equals `MAX_RETRY`, go to FAULT; otherwise go to RESET_PLL.
- RELEASE:
  - `domain_rst_n[0]` goes high on the first RELEASE cycle.
  - `domain_rst_n[i]` goes high `STAGGER*i` cycles after bit 0.
  - On the cycle bit `NUM_CLKS-1` rises, `ready`=1 and the state moves to RUN.
- RUN: holding state. `retry_cnt` clears to 0 on entry, because a successful lock resets the retry budget.
- Lock loss (`lock_s`=0 in RELEASE or RUN):
  - On the next edge, all `domain_rst_n` go to 0 and `ready` goes to 0.
  - `retry_cnt`+1, then the same MAX_RETRY check as a timeout.
- FAULT: `pll_rst`=1, all domains held in reset, `fault`=1. Exits only via `restart` or `rst_n`.
- `restart`:
  - Honoured in every state and has priority over every other event in the same cycle.
  - Next state is RESET_PLL with `retry_cnt`=0, `fault`=0, `ready`=0 and all domains in reset.
- Reset values: `pll_rst`=1, `domain_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, all counters 0.

## Timing
- All outputs are registered and none has a combinational path from an input.
- Lock latency:
  - A `lock` edge is visible on `lock_s` 2 cycles later.
  - Entry to RELEASE comes `LOCK_FILTER` cycles after the first high `lock_s`.
  - `domain_rst_n[0]` rises 1 cycle after that.
- From `rst_n` deassertion, `pll_rst` stays high for exactly `RST_HOLD` rising edges.
- A lock glitch shorter than the filter in WAIT_LOCK only restarts the filter count. It does not consume a retry.
- The timeout counter runs from WAIT_LOCK entry and is not cleared by filter restarts.
- Asserting `rst_n` in any state forces reset values asynchronously, including in the middle of a RELEASE stagger.
- Counter widths are `$clog2(max+1)` of each parameter. No counter wraps, because each saturates at its terminal value.

## Structure
- `pll_pkg` holds the state encoding constants (5 states, 3 bits) and the parameter range checks.
- Sub-module `lock_sync`: 2-FF synchroniser with `(* ASYNC_REG *)` and an async active-low reset to 0. It is instantiated once, for `lock`.
- The existing PLL wrapper's `lock` output connects directly to `lock`. `pll_rst` drives the EHXPLLL `RST` pin, which needs `PLLRST_ENA("ENABLED")`.

## Test plan
All scenarios use the default parameters.
- Clean start: hold `lock`=0 during reset, raise it 50 cycles after reset release. Expect:
  - `pll_rst` high for 8 cycles;
  - `domain_rst_n` stepping 0001, 0011, 0111, 1111 at 4-cycle intervals;
  - `ready`=1 together with 1111 and `retry_cnt`=0.
- Glitch filter: pulse `lock` high for 10 cycles, low for 5, then hold it high. Expect the release to start only after 16 consecutive high `lock_s` samples, with no retry counted.
- Lock loss in RUN: drop `lock` for 3 cycles. Expect:
  - `domain_rst_n`=0000 and `ready`=0 three cycles after the drop;
  - `retry_cnt`=1;
  - `pll_rst` high for 8 cycles, then a full re-sequence once lock returns, with `retry_cnt`=0 in RUN.
- Timeout to fault: hold `lock`=0 permanently. Expect 3 attempts of 8+1000 cycles each, then `fault`=1, `pll_rst`=1 held and `retry_cnt`=3.
- Restart priority: pulse `restart` in FAULT, and separately in RELEASE with bits 0011 already released in the same cycle as a lock loss. Expect RESET_PLL, `fault`=0 and `retry_cnt`=0 in both cases.
- Async reset mid-RELEASE: assert `rst_n` between two stagger steps. Expect every output at its reset value immediately, without waiting for a clock edge.
